// File: rtl/divider_4b_seq_pkg.sv
// Shared arithmetic definitions for the sequential restoring divider:
// default operand width, controller states and the counter width helper.
package divider_4b_seq_pkg;

   localparam int W_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bits needed to count the 2W quotient steps.
   function automatic int cntWidth(input int w);
      return (2 * w <= 2) ? 1 : $clog2(2 * w);
   endfunction

endpackage

// File: rtl/divider_4b_seq_div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor at W+1 bits and keep the difference
// only when it does not go negative.
module div_step #(
   parameter int W = 4
) (
   input  logic [W-1:0] rem_i,
   input  logic         bit_i,
   input  logic [W-1:0] y_i,
   output logic [W-1:0] rem_o,
   output logic         qbit_o
);

   logic [W:0] trial;

   // The retained remainder is always narrower than the divisor, so only its
   // low W bits are carried in; the shifted trial value needs the extra bit.
   // A W-bit subtract gives the correct low bits of the W+1-bit difference.
   always_comb begin
      trial  = {rem_i, bit_i};
      qbit_o = (trial >= {1'b0, y_i});
      rem_o  = qbit_o ? (trial[W-1:0] - y_i) : trial[W-1:0];
   end

endmodule

// File: rtl/divider_4b_seq.sv
// Sequential radix-2 restoring divider: 2W-bit dividend by W-bit divisor,
// one quotient bit per clock, valid/ready handshakes on input and output.
module divider_4b_seq
   import divider_4b_seq_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] x,
   input  logic [W-1:0]   y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] q,
   output logic [W-1:0]   r,
   output logic           dbz
);

   localparam int CW = cntWidth(W);

   state_e         state_q;
   logic           inReady_q;
   logic           outValid_q;
   logic [2*W-1:0] xsh_q;
   logic [W-1:0]   y_q;
   logic [W-1:0]   xLow_q;
   logic [W-1:0]   rem_q;
   logic [CW-1:0]  cnt_q;
   logic           dbzInt_q;
   logic [2*W-1:0] quo_q;
   logic [W-1:0]   remOut_q;
   logic           dbzOut_q;

   logic [W-1:0]   rem_d;
   logic           qbit_d;
   logic [2*W-1:0] xsh_d;

   div_step #(.W(W)) u_step (
      .rem_i  (rem_q),
      .bit_i  (xsh_q[2*W-1]),
      .y_i    (y_q),
      .rem_o  (rem_d),
      .qbit_o (qbit_d)
   );

   // The dividend shifts out of the top while quotient bits fill in from the bottom.
   assign xsh_d = {xsh_q[2*W-2:0], qbit_d};

   // Controller and datapath: accept, iterate 2W steps, hold result until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
         xsh_q      <= '0;
         y_q        <= '0;
         xLow_q     <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         dbzInt_q   <= 1'b0;
         quo_q      <= '0;
         remOut_q   <= '0;
         dbzOut_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && inReady_q) begin
                  state_q   <= CALC;
                  inReady_q <= 1'b0;
                  xsh_q     <= x;
                  y_q       <= y;
                  xLow_q    <= x[W-1:0];
                  rem_q     <= '0;
                  cnt_q     <= CW'(2 * W - 1);
                  dbzInt_q  <= (y == '0);
               end
            end
            CALC: begin
               xsh_q <= xsh_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_q    <= DONE;
                  outValid_q <= 1'b1;
                  dbzOut_q   <= dbzInt_q;
                  if (dbzInt_q) begin
                     quo_q    <= '1;
                     remOut_q <= xLow_q;
                  end else begin
                     quo_q    <= xsh_d;
                     remOut_q <= rem_d;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q    <= IDLE;
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
               end
            end
            default: begin
               state_q    <= IDLE;
               outValid_q <= 1'b0;
               inReady_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign q         = quo_q;
   assign r         = remOut_q;
   assign dbz       = dbzOut_q;

endmodule

// File: tb/tb_divider_4b_seq.sv
// Self-checking bench for divider_4b_seq: directed cases, divide-by-zero,
// output backpressure, asynchronous abort and a full operand sweep with
// random stalls, all compared against a plain-arithmetic reference.
module tb_divider_4b_seq;

   localparam int W = 4;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [2*W-1:0] x;
   logic [W-1:0]   y;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] q;
   logic [W-1:0]   r;
   logic           dbz;

   int checks = 0;
   int errors = 0;

   divider_4b_seq #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .r         (r),
      .dbz       (dbz)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference quotient: integer division, all ones on a zero divisor.
   function automatic logic [7:0] refQuot(input logic [7:0] xv, input logic [3:0] yv);
      if (yv == 4'd0) return 8'hFF;
      return 8'(int'(xv) / int'(yv));
   endfunction

   // Reference remainder: modulo, original low dividend bits on a zero divisor.
   function automatic logic [3:0] refRem(input logic [7:0] xv, input logic [3:0] yv);
      if (yv == 4'd0) return xv[3:0];
      return 4'(int'(xv) % int'(yv));
   endfunction

   // 4x4 array multiplier model: sum of shifted partial products.
   function automatic int mul4(input logic [3:0] a, input logic [3:0] b);
      int p;
      p = 0;
      for (int i = 0; i < 4; i++)
         if (b[i]) p = p + (int'(a) << i);
      return p;
   endfunction

   // Offer one operand pair, then wait for out_valid counting edges after accept.
   // Enters and leaves 1 time unit after a rising edge; leaves out_ready low.
   task automatic applyStimulus(input logic [7:0] xv, input logic [3:0] yv,
                                output int lat, output bit timedOut);
      int guard;
      timedOut = 1'b0;
      lat      = 0;
      guard    = 0;
      x        = xv;
      y        = yv;
      in_valid = 1'b1;
      while (!in_ready && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!in_ready) timedOut = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x        = 8'($urandom);
      y        = 4'($urandom);
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) timedOut = 1'b1;
   endtask

   // Accept the pending result with a one-cycle out_ready pulse.
   task automatic releaseOutput();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      y         = '0;
      #12;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
      checks++;
      if (q !== 8'd0 || r !== 4'd0 || dbz !== 1'b0)
         begin errors++; $display("[TB] FAIL reset_result got q=%0d r=%0d dbz=%b expected 0 0 0", q, r, dbz); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %b expected 1", in_ready); end
   endtask

   task automatic test_directed();
      int  xs [4] = '{200, 255, 0, 7};
      int  ys [4] = '{13, 1, 15, 0};
      int  lat;
      bit  to;
      logic [7:0] xv;
      logic [3:0] yv;
      for (int i = 0; i < 4; i++) begin
         xv = 8'(xs[i]);
         yv = 4'(ys[i]);
         applyStimulus(xv, yv, lat, to);
         checks++;
         if (to) begin errors++; $display("[TB] FAIL directed_timeout x=%0d y=%0d no result within bound", xv, yv); end
         checks++;
         if (lat != 8) begin errors++; $display("[TB] FAIL directed_latency x=%0d y=%0d got %0d expected 8", xv, yv, lat); end
         checks++;
         if (q !== refQuot(xv, yv)) begin errors++; $display("[TB] FAIL directed_q x=%0d y=%0d got %0d expected %0d", xv, yv, q, refQuot(xv, yv)); end
         checks++;
         if (r !== refRem(xv, yv)) begin errors++; $display("[TB] FAIL directed_r x=%0d y=%0d got %0d expected %0d", xv, yv, r, refRem(xv, yv)); end
         checks++;
         if (dbz !== (yv == 4'd0)) begin errors++; $display("[TB] FAIL directed_dbz x=%0d y=%0d got %b expected %b", xv, yv, dbz, (yv == 4'd0)); end
         releaseOutput();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL directed_release got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bit to;
      applyStimulus(8'd100, 4'd9, lat, to);
      checks++;
      if (to) begin errors++; $display("[TB] FAIL bp_timeout no result within bound"); end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL bp_handshake cycle %0d got out_valid=%b in_ready=%b expected 1 0", c, out_valid, in_ready); end
         checks++;
         if (q !== 8'd11 || r !== 4'd1 || dbz !== 1'b0)
            begin errors++; $display("[TB] FAIL bp_stable cycle %0d got q=%0d r=%0d dbz=%b expected 11 1 0", c, q, r, dbz); end
         @(posedge clk);
         #1;
      end
      releaseOutput();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin errors++; $display("[TB] FAIL bp_idle_after got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
   endtask

   task automatic test_abort();
      int guard;
      int lat;
      bit to;
      guard    = 0;
      x        = 8'd201;
      y        = 4'd7;
      in_valid = 1'b1;
      while (!in_ready && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0)
         begin errors++; $display("[TB] FAIL abort_busy got in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         begin errors++; $display("[TB] FAIL abort_immediate got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(8'd64, 4'd8, lat, to);
      checks++;
      if (to || lat != 8) begin errors++; $display("[TB] FAIL abort_fresh_latency got %0d timeout=%b expected 8", lat, to); end
      checks++;
      if (q !== 8'd8 || r !== 4'd0 || dbz !== 1'b0)
         begin errors++; $display("[TB] FAIL abort_fresh_result got q=%0d r=%0d dbz=%b expected 8 0 0", q, r, dbz); end
      releaseOutput();
   endtask

   task automatic test_sweep();
      int lat;
      bit to;
      logic [7:0] xv;
      logic [3:0] yv;
      for (int xi = 0; xi < 256; xi++) begin
         for (int yi = 0; yi < 16; yi++) begin
            xv = 8'(xi);
            yv = 4'(yi);
            if ($urandom_range(3) == 0) begin
               @(posedge clk);
               #1;
            end
            applyStimulus(xv, yv, lat, to);
            checks++;
            if (to || lat != 8) begin errors++; $display("[TB] FAIL sweep_latency x=%0d y=%0d got %0d timeout=%b expected 8", xv, yv, lat, to); end
            checks++;
            if (q !== refQuot(xv, yv) || r !== refRem(xv, yv) || dbz !== (yv == 4'd0))
               begin errors++; $display("[TB] FAIL sweep_result x=%0d y=%0d got q=%0d r=%0d dbz=%b expected %0d %0d %b",
                                        xv, yv, q, r, dbz, refQuot(xv, yv), refRem(xv, yv), (yv == 4'd0)); end
            if (yv != 4'd0) begin
               checks++;
               if (int'(q) * int'(yv) + int'(r) != int'(xv) || r >= yv)
                  begin errors++; $display("[TB] FAIL sweep_identity x=%0d y=%0d got q=%0d r=%0d expected q*y+r=x and r<y", xv, yv, q, r); end
               if (q < 8'd16) begin
                  checks++;
                  if (mul4(q[3:0], yv) + int'(r) != int'(xv))
                     begin errors++; $display("[TB] FAIL sweep_mul4 x=%0d y=%0d got %0d expected %0d", xv, yv, mul4(q[3:0], yv) + int'(r), xv); end
               end
            end
            if ($urandom_range(3) == 0) begin
               @(posedge clk);
               #1;
            end
            releaseOutput();
         end
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_abort();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
